// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues one 32-bit fetch at a time to
// instruction memory and holds the fetched word in an output slot for the decoder.
// Redirects flush the slot and discard stale responses that are in flight.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect raises a
// sticky fault entry instead of fetching).
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  typedef enum logic [1:0] {StReq, StWait, StDrain, StHalt} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        req_en_q;
  logic        slot_free;
  logic        req_fire;
  logic [31:0] redirect_target;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  // Tracks an accepted request whose response has not yet returned, so leaving
  // HALT can still drain a response that was in flight when the fault hit.
  logic outstanding_q, outstanding_d;
  logic redirect_misaligned;

  assign redirect_misaligned = |redirect_pc[1:0];
  assign redirect_target     = redirect_pc;
  assign inst_fault          = fault_q;
`else
  // Low address bits are dropped so fetches are always word aligned.
  assign redirect_target = redirect_pc & ~32'h0000_0003;
  assign inst_fault      = 1'b0;
`endif

  // req_en_q keeps the request low until the first edge after reset release.
  assign slot_free      = !inst_valid_q || inst_ready;
  assign imem_req_valid = req_en_q && (state_q == StReq) && slot_free;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_out_q;
  assign inst_pc    = inst_pc_q;

  // Next-state: redirect first, then normal fetch sequencing.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_valid_d = inst_valid_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d       = fault_q;
    outstanding_d = outstanding_q;
    if (imem_resp_valid) outstanding_d = 1'b0;
    if (req_fire)        outstanding_d = 1'b1;
`endif

    // Transfer empties the slot; a fault entry in HALT is sticky.
    if (inst_valid_q && inst_ready && (state_q != StHalt)) inst_valid_d = 1'b0;

    if (redirect_valid) begin
      pc_d         = redirect_target;
      inst_valid_d = 1'b0;
      case (state_q)
        StReq:   state_d = req_fire ? StDrain : StReq;
        StWait:  state_d = imem_resp_valid ? StReq : StDrain;
        StDrain: state_d = imem_resp_valid ? StReq : StDrain;
        default: begin
`ifdef FETCH_ALIGN_CHECK_EN
          state_d = (outstanding_q && !imem_resp_valid) ? StDrain : StReq;
`else
          state_d = StReq;
`endif
        end
      endcase
`ifdef FETCH_ALIGN_CHECK_EN
      fault_d = 1'b0;
      if (redirect_misaligned) begin
        state_d      = StHalt;
        inst_valid_d = 1'b1;
        fault_d      = 1'b1;
        inst_out_d   = 32'h0;
        inst_pc_d    = redirect_pc;
      end
`endif
    end else begin
      case (state_q)
        StReq: begin
          if (req_fire) state_d = StWait;
        end
        StWait: begin
          if (imem_resp_valid) begin
            inst_out_d   = imem_resp_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
            state_d      = StReq;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_d      = 1'b0;
`endif
          end
        end
        StDrain: begin
          if (imem_resp_valid) state_d = StReq;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State and output-slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_out_q   <= 32'h0;
      inst_pc_q    <= 32'h0;
      req_en_q     <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q       <= 1'b0;
      outstanding_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      req_en_q     <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q       <= fault_d;
      outstanding_q <= outstanding_d;
`endif
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed stimulus pushes expected
// instructions; a negedge monitor pops and compares on every transfer.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_fault;

  instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_out        (inst_out),
    .inst_pc         (inst_pc),
    .inst_fault      (inst_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] acc_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          mem_lat = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] data, input logic fault);
    exp_t e;
    e.pc = pc; e.data = data; e.fault = fault;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Memory contents: upper half is the inverted low half of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory model: accepts at negedge sample, answers mem_lat cycles later.
  logic        mem_acc;
  logic [31:0] mem_acc_addr;
  logic [31:0] mem_paddr = 32'h0;
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  always begin
    @(negedge clk);
    mem_acc      = imem_req_valid && imem_req_ready;
    mem_acc_addr = imem_req_addr;
    @(posedge clk);
    #1;
    imem_resp_valid = 1'b0;
    if (mem_acc) begin
      mem_pend  = 1'b1;
      mem_cnt   = mem_lat;
      mem_paddr = mem_acc_addr;
      acc_q.push_back(mem_acc_addr);
    end
    if (mem_pend) begin
      if (mem_cnt <= 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_paddr);
        mem_pend        = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
  end

  // Monitor: compare every transferred instruction against the scoreboard.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_inst: got pc %h data %h, required no transfer", inst_pc, inst_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("inst_pc", inst_pc, mon_e.pc);
        check("inst_out", inst_out, mon_e.data);
        check("inst_fault", 32'(inst_fault), 32'(mon_e.fault));
      end
    end
  end

  logic [31:0] acc_exp[$];
  logic        found;

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;

    // Reset state with the clock running.
    repeat (2) step();
    sample();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0000_0100);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_out", inst_out, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_inst_fault", 32'(inst_fault), 32'd0);

    push_exp(32'h0000_0100, 32'hFEFF_0100, 1'b0);
    push_exp(32'h0000_0104, 32'hFEFB_0104, 1'b0);
    push_exp(32'h0000_0108, 32'hFEF7_0108, 1'b0);
    push_exp(32'h0000_010C, 32'hFEF3_010C, 1'b0);
    push_exp(32'h0000_0200, 32'hFDFF_0200, 1'b0);
    push_exp(32'h0000_0040, 32'hFFBF_0040, 1'b0);
`ifndef FETCH_ALIGN_CHECK_EN
    push_exp(32'h0000_0300, 32'hFCFF_0300, 1'b0);
`endif

    step();
    rst_n = 1'b1;

    // Sequential fetch: inst_valid on every second cycle.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      sample();
      if (inst_valid) found = 1'b1;
    end
    check("first_valid_seen", 32'(found), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      sample();
      check("valid_alternate", 32'(inst_valid), 32'(i % 2));
    end

    // Decoder stall with 0x10C held in the slot.
    step();
    inst_ready = 1'b0;
    sample();
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) mem_lat = 3;
      sample();
      check("stall_valid", 32'(inst_valid), 32'd1);
      check("stall_pc", inst_pc, 32'h0000_010C);
      check("stall_out", inst_out, 32'hFEF3_010C);
      check("stall_no_req", 32'(imem_req_valid), 32'd0);
    end
    step();
    inst_ready = 1'b1;
    sample();
    check("resume_req_valid", 32'(imem_req_valid), 32'd1);
    check("resume_req_addr", imem_req_addr, 32'h0000_0110);

    // Redirect while waiting on a 3-cycle response.
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    sample();
    check("wait_no_req", 32'(imem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    mem_lat        = 1;
    sample();
    check("drain_no_req", 32'(imem_req_valid), 32'd0);

    // Redirect in the same cycle as the response for 0x204.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      sample();
      if (imem_req_valid && imem_req_ready && imem_req_addr == 32'h0000_0204) found = 1'b1;
    end
    check("reach_req_204", 32'(found), 32'd1);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0280;
    sample();
    check("coinc_valid", 32'(inst_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    sample();
    check("coinc_dropped", 32'(inst_valid), 32'd0);
    check("coinc_req_valid", 32'(imem_req_valid), 32'd1);
    check("coinc_req_addr", imem_req_addr, 32'h0000_0280);

    // Unaccepted request, then redirect to 0x40.
    for (int i = 0; i < 3; i++) begin
      step();
      sample();
      check("hold_req_addr", imem_req_addr, 32'h0000_0280);
    end
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    sample();
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    sample();
    check("redir_req_valid", 32'(imem_req_valid), 32'd1);
    check("redir_req_addr", imem_req_addr, 32'h0000_0040);
    step();
    imem_req_ready = 1'b0;
    sample();
    repeat (2) begin
      step();
      sample();
    end

    // Misaligned redirect to 0x302.
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0302;
`ifdef FETCH_ALIGN_CHECK_EN
    inst_ready = 1'b0;
`endif
    sample();
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    sample();
`ifdef FETCH_ALIGN_CHECK_EN
    check("fault_no_req", 32'(imem_req_valid), 32'd0);
    check("fault_valid", 32'(inst_valid), 32'd1);
    check("fault_flag", 32'(inst_fault), 32'd1);
    check("fault_pc", inst_pc, 32'h0000_0302);
    check("fault_out", inst_out, 32'h0);
    repeat (3) begin
      step();
      sample();
    end
    check("halt_no_req", 32'(imem_req_valid), 32'd0);
    check("halt_valid", 32'(inst_valid), 32'd1);
`else
    check("align_req_valid", 32'(imem_req_valid), 32'd1);
    check("align_req_addr", imem_req_addr, 32'h0000_0300);
    step();
    imem_req_ready = 1'b0;
    sample();
    repeat (3) begin
      step();
      sample();
    end
`endif

    // Every expected instruction delivered, and only the expected fetches issued.
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    acc_exp = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h200, 32'h204, 32'h40};
`ifndef FETCH_ALIGN_CHECK_EN
    acc_exp.push_back(32'h300);
`endif
    check("accept_count", 32'(acc_q.size()), 32'(acc_exp.size()));
    for (int i = 0; i < acc_exp.size() && i < acc_q.size(); i++) begin
      check("accept_addr", acc_q[i], acc_exp[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
